spi_adc_responder: RTL and testbench

Serial-ADC responder: the device end of the 3-wire SPI link (cs, s_clk, s_data) that the TSAL controller uses to read its voltage sample. It presents an 8-bit sample as an ADC081S-style frame to an external initiator clocked from a separate source. It is used as an on-chip loopback target for the TSAL threshold path and as the bench model's synthesizable twin. All link inputs are treated as asynchronous and oversampled on clk.

---
 rtl/spi_adc_responder.sv | 117 +++++++++++
 tb/tb_spi_adc_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spi_adc_responder.sv
// Device end of a 3-wire SPI link presenting an 8-bit sample as an ADC081S-style frame.
// cs and s_clk are asynchronous to clk and are oversampled through 2-flop synchronizers.
module spi_adc_responder #(
  parameter int LEAD_ZEROS = 3,
  parameter int DATA_W     = 8,
  parameter int FRAME_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              cs,
  input  logic              s_clk,
  output logic              s_data,
  output logic              s_data_oe,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LZ  = CW'(LEAD_ZEROS);
  localparam logic [CW-1:0] LZD = CW'(LEAD_ZEROS + DATA_W);
  localparam logic [CW-1:0] FB  = CW'(FRAME_BITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [2:0]        cs_sh;
  logic [2:0]        sclk_sh;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] snap_r;
  logic [DATA_W-1:0] snap_new;
  logic [CW-1:0]     bit_idx;
  logic [CW-1:0]     rise_cnt;
  logic [CW-1:0]     idx_nxt;
  logic              cs_fall, cs_rise, sclk_rise, sclk_fall;

  // Bit 1 of each shift chain is the synchronized copy, bit 2 its one-cycle history.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      cs_sh   <= 3'b111;
      sclk_sh <= 3'b000;
    end else begin
      cs_sh   <= {cs_sh[1:0], cs};
      sclk_sh <= {sclk_sh[1:0], s_clk};
    end
  end

  assign cs_fall   =  cs_sh[2]   & ~cs_sh[1];
  assign cs_rise   = ~cs_sh[2]   &  cs_sh[1];
  assign sclk_rise = ~sclk_sh[2] &  sclk_sh[1];
  assign sclk_fall =  sclk_sh[2] & ~sclk_sh[1];

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn)          hold_r <= '0;
    else if (sample_valid) hold_r <= sample_in;
  end

  // A sample offered in the very cycle the frame starts wins over the held value.
  assign snap_new = sample_valid ? sample_in : hold_r;
  assign idx_nxt  = (bit_idx == FB) ? FB : bit_idx + 1'b1;

  function automatic logic frame_bit(input logic [DATA_W-1:0] snap, input logic [CW-1:0] idx);
    logic [DATA_W-1:0] sh;
    sh = snap << (idx - LZ);
    frame_bit = (idx >= LZ && idx < LZD) ? sh[DATA_W-1] : 1'b0;
  endfunction

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state       <= IDLE;
      snap_r      <= '0;
      bit_idx     <= '0;
      rise_cnt    <= '0;
      s_data      <= 1'b0;
      s_data_oe   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            snap_r    <= snap_new;
            bit_idx   <= '0;
            rise_cnt  <= '0;
            s_data    <= frame_bit(snap_new, {CW{1'b0}});
            s_data_oe <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          // cs edge outranks any s_clk edge seen in the same cycle.
          if (cs_rise) begin
            state     <= IDLE;
            s_data    <= 1'b0;
            s_data_oe <= 1'b0;
            busy      <= 1'b0;
            if (rise_cnt == FB) frame_done  <= 1'b1;
            else                frame_abort <= 1'b1;
          end else if (sclk_rise) begin
            rise_cnt <= (rise_cnt == FB) ? FB : rise_cnt + 1'b1;
          end else if (sclk_fall) begin
            bit_idx <= idx_nxt;
            s_data  <= frame_bit(snap_r, idx_nxt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: drives the SPI initiator side and checks
// sampled frame bits, timing of oe/busy and the frame_done/frame_abort pulses.
module tb_spi_adc_responder;

  logic       clk = 1'b0;
  logic       rst_btn;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       cs;
  logic       s_clk;
  logic       s_data;
  logic       s_data_oe;
  logic       busy;
  logic       frame_done;
  logic       frame_abort;

  int n_vec = 0;
  int n_bad = 0;
  int done_cyc = 0;
  int abort_cyc = 0;

  always #5 clk = ~clk;

  spi_adc_responder dut (
    .clk          (clk),
    .rst_btn      (rst_btn),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .cs           (cs),
    .s_clk        (s_clk),
    .s_data       (s_data),
    .s_data_oe    (s_data_oe),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort)
  );

  // Counts cycles each pulse is high; a single clean pulse adds exactly 1.
  always @(posedge clk) begin
    if (frame_done)  done_cyc  <= done_cyc + 1;
    if (frame_abort) abort_cyc <= abort_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    wait_n(1);
    sample_valid = 1'b0;
  endtask

  function automatic logic [4:0] outs();
    return {s_data, s_data_oe, busy, frame_done, frame_abort};
  endfunction

  task automatic run_frame(input string tag, input int n,
                           input logic early, input logic [7:0] early_v,
                           input logic mid, input logic [7:0] mid_v,
                           input logic [31:0] exp_bits);
    logic [31:0] bits;
    int d0, a0;
    bits = '0;
    d0 = done_cyc;
    a0 = abort_cyc;
    cs = 1'b0;
    wait_n(2);
    chk({tag, "_oe_early"}, {31'b0, s_data_oe}, 32'd0);
    if (early) begin
      sample_in    = early_v;
      sample_valid = 1'b1;
    end
    wait_n(1);
    sample_valid = 1'b0;
    chk({tag, "_oe_busy_start"}, {30'b0, s_data_oe, busy}, 32'd3);
    wait_n(2);
    for (int i = 0; i < n; i++) begin
      bits  = {bits[30:0], s_data};
      s_clk = 1'b1;
      wait_n(5);
      s_clk = 1'b0;
      if (mid && i == 8) begin
        sample_in    = mid_v;
        sample_valid = 1'b1;
        wait_n(1);
        sample_valid = 1'b0;
        wait_n(4);
      end else begin
        wait_n(5);
      end
    end
    chk({tag, "_bits"}, bits, exp_bits);
    cs = 1'b1;
    wait_n(2);
    chk({tag, "_pulse_pre"}, {30'b0, frame_done, frame_abort}, 32'd0);
    wait_n(1);
    chk({tag, "_pulse_at3"}, {27'b0, outs()},
        (n >= 16) ? 32'b00010 : 32'b00001);
    wait_n(4);
    chk({tag, "_done_cnt"},  done_cyc - d0,  (n >= 16) ? 32'd1 : 32'd0);
    chk({tag, "_abort_cnt"}, abort_cyc - a0, (n >= 16) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int d0, a0;
    rst_btn      = 1'b0;
    cs           = 1'b1;
    s_clk        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    wait_n(3);
    chk("reset_outs", {27'b0, outs()}, 32'd0);
    rst_btn = 1'b1;
    wait_n(3);
    chk("post_reset_outs", {27'b0, outs()}, 32'd0);

    load(8'hA5);
    run_frame("a5", 16, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0000_14A0);

    load(8'h3C);
    run_frame("3c_mid_ff", 16, 1'b0, 8'h00, 1'b1, 8'hFF, 32'h0000_0780);
    run_frame("ff_next", 16, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0000_1FE0);

    run_frame("abort7", 7, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0000_000F);
    load(8'h96);
    run_frame("after_abort", 16, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0000_12C0);

    load(8'h81);
    run_frame("over20", 20, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0001_0200);

    // Reset in the middle of a frame while s_data is driving a 1.
    load(8'hFF);
    cs = 1'b0;
    wait_n(5);
    for (int i = 0; i < 4; i++) begin
      s_clk = 1'b1;
      wait_n(5);
      s_clk = 1'b0;
      wait_n(5);
    end
    chk("midframe_pre_rst", {29'b0, s_data, s_data_oe, busy}, 32'd7);
    d0 = done_cyc;
    a0 = abort_cyc;
    #2 rst_btn = 1'b0;
    #1 chk("rst_immediate", {27'b0, outs()}, 32'd0);
    wait_n(2);
    cs = 1'b1;
    wait_n(3);
    rst_btn = 1'b1;
    wait_n(8);
    chk("rst_no_pulse", (done_cyc - d0) + (abort_cyc - a0), 32'd0);
    chk("rst_outs_idle", {27'b0, outs()}, 32'd0);
    load(8'h5A);
    run_frame("5a_after_rst", 16, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0000_0B40);

    run_frame("early77", 16, 1'b1, 8'h77, 1'b0, 8'h00, 32'h0000_0EE0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
